// File: rtl/circ_interp_pipe.sv
`default_nettype none
// +------------------------------------------------------------------+
// | circ_interp_pipe: 3-stage circular-neighbourhood interpolator     |
// | Rev 1.0 - initial release                                         |
// +------------------------------------------------------------------+
module circ_interp_pipe #(
  parameter int DW     = 8,
  parameter int FW     = 8,
  parameter int W_FRAC = 75
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic             mode_i,
  input  logic             done_i,
  input  logic [DW-1:0]    mid_i,
  input  logic [4*DW-1:0]  axial_i,
  input  logic [16*DW-1:0] diag_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [8*DW-1:0]  samples_o,
  output logic [DW-1:0]    mid_o,
  output logic             done_o
);

  localparam int c_aw  = 2*FW + DW + 2;
  localparam int c_one = 1 << FW;
  localparam logic [c_aw-1:0] c_wa    = c_aw'((c_one - W_FRAC) * (c_one - W_FRAC));
  localparam logic [c_aw-1:0] c_wb    = c_aw'(W_FRAC * (c_one - W_FRAC));
  localparam logic [c_aw-1:0] c_wd    = c_aw'(W_FRAC * W_FRAC);
  localparam logic [c_aw-1:0] c_round = c_aw'(64'd1 << (2*FW - 1));
  localparam logic [c_aw-1:0] c_max   = c_aw'({DW{1'b1}});
  // corner weights indexed by corner number: c1, c2, c3, c4
  localparam logic [3:0][c_aw-1:0] c_w = {c_wd, c_wb, c_wb, c_wa};

  logic w_advance;

  logic              r_s1_vld, r_s1_mode, r_s1_done;
  logic [DW-1:0]     r_s1_mid;
  logic [4*DW-1:0]   r_s1_axial;
  logic [16*DW-1:0]  r_s1_diag;

  logic              r_s2_vld, r_s2_mode, r_s2_done;
  logic [DW-1:0]     r_s2_mid;
  logic [4*DW-1:0]   r_s2_axial;
  logic [15:0][c_aw-1:0] r_s2_prod;
  logic [3:0][DW-1:0]    r_s2_c1;

  logic [15:0][c_aw-1:0] w_prod;
  logic [3:0][DW-1:0]    w_c1;
  logic [3:0][DW-1:0]    w_diag;
  logic [8*DW-1:0]       w_samples;

  logic r_s3_vld, r_s3_done;

  // global stall: the whole pipe freezes while the output beat is held
  assign w_advance = !r_s3_vld || ready_i;
  assign ready_o   = w_advance;
  assign valid_o   = r_s3_vld;
  assign done_o    = r_s3_vld && r_s3_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_vld   <= 1'b0;
      r_s1_mode  <= 1'b0;
      r_s1_done  <= 1'b0;
      r_s1_mid   <= '0;
      r_s1_axial <= '0;
      r_s1_diag  <= '0;
    end else if (w_advance) begin
      r_s1_vld   <= valid_i;
      r_s1_mode  <= mode_i;
      r_s1_done  <= valid_i && done_i;
      r_s1_mid   <= mid_i;
      r_s1_axial <= axial_i;
      r_s1_diag  <= diag_i;
    end
  end

  generate
    for (genvar d = 0; d < 4; d++) begin : g_diag
      assign w_c1[d] = r_s1_diag[(4*d)*DW +: DW];
      for (genvar k = 0; k < 4; k++) begin : g_corner
        assign w_prod[4*d+k] = c_aw'(r_s1_diag[(4*d+k)*DW +: DW]) * c_w[k];
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_vld   <= 1'b0;
      r_s2_mode  <= 1'b0;
      r_s2_done  <= 1'b0;
      r_s2_mid   <= '0;
      r_s2_axial <= '0;
      r_s2_prod  <= '0;
      r_s2_c1    <= '0;
    end else if (w_advance) begin
      r_s2_vld   <= r_s1_vld;
      r_s2_mode  <= r_s1_mode;
      r_s2_done  <= r_s1_done;
      r_s2_mid   <= r_s1_mid;
      r_s2_axial <= r_s1_axial;
      r_s2_prod  <= w_prod;
      r_s2_c1    <= w_c1;
    end
  end

  generate
    for (genvar d = 0; d < 4; d++) begin : g_sum
      logic [c_aw-1:0] w_acc;
      logic [c_aw-1:0] w_q;
      assign w_acc = r_s2_prod[4*d] + r_s2_prod[4*d+1] + r_s2_prod[4*d+2]
                   + r_s2_prod[4*d+3] + c_round;
      assign w_q   = w_acc >> (2*FW);
      assign w_diag[d] = r_s2_mode   ? r_s2_c1[d] :
                         (w_q > c_max) ? {DW{1'b1}} : w_q[DW-1:0];
      // interleave: even slots axial, odd slots diagonal
      assign w_samples[(2*d)*DW   +: DW] = r_s2_axial[d*DW +: DW];
      assign w_samples[(2*d+1)*DW +: DW] = w_diag[d];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s3_vld  <= 1'b0;
      r_s3_done <= 1'b0;
      samples_o <= '0;
      mid_o     <= '0;
    end else if (w_advance) begin
      r_s3_vld  <= r_s2_vld;
      r_s3_done <= r_s2_done;
      samples_o <= w_samples;
      mid_o     <= r_s2_mid;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_circ_interp_pipe.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_circ_interp_pipe: scoreboard bench for circ_interp_pipe        |
// | Rev 1.0 - initial release                                         |
// +------------------------------------------------------------------+
module tb_circ_interp_pipe;

  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            valid_i = 1'b0;
  logic            ready_o;
  logic            mode_i = 1'b0;
  logic            done_i = 1'b0;
  logic [DW-1:0]   mid_i = '0;
  logic [4*DW-1:0] axial_i = '0;
  logic [16*DW-1:0] diag_i = '0;
  logic            valid_o;
  logic            ready_i = 1'b1;
  logic [8*DW-1:0] samples_o;
  logic [DW-1:0]   mid_o;
  logic            done_o;

  typedef struct packed {
    logic [8*DW-1:0] s;
    logic [DW-1:0]   m;
    logic            d;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  circ_interp_pipe u_dut (
    .clk       (clk),
    .rst       (rst),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .mode_i    (mode_i),
    .done_i    (done_i),
    .mid_i     (mid_i),
    .axial_i   (axial_i),
    .diag_i    (diag_i),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .samples_o (samples_o),
    .mid_o     (mid_o),
    .done_o    (done_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pk4(input int a, input int b, input int c, input int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  function automatic logic [63:0] pk8(input int s1, input int s2, input int s3, input int s4,
                                      input int s5, input int s6, input int s7, input int s8);
    return {pk4(s5, s6, s7, s8), pk4(s1, s2, s3, s4)};
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // caller enters just after a rising edge
  task automatic send(input logic m, input logic d, input int mid, input logic [31:0] ax,
                      input logic [127:0] dg, input logic [63:0] exp_s);
    int t;
    exp_t e;
    valid_i = 1'b1; mode_i = m; done_i = d; mid_i = 8'(mid); axial_i = ax; diag_i = dg;
    t = 0;
    @(negedge clk);
    while (!ready_o && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!ready_o) begin
      n_vec++; n_fail++;
      $display("FAIL send_timeout: ready_o stuck at %b, required 1", ready_o);
    end else begin
      e.s = exp_s; e.m = 8'(mid); e.d = d;
      sb_q.push_back(e);
    end
    @(posedge clk); #1;
    valid_i = 1'b0; done_i = 1'b0;
  endtask

  task automatic drain;
    int t;
    t = 0;
    while (sb_q.size() != 0 && t < 60) begin
      @(negedge clk);
      t++;
    end
    chk("drain_pending", 64'(sb_q.size()), 64'd0);
  endtask

  // monitor / scoreboard
  exp_t prev;
  bit   have_prev = 1'b0;
  always @(negedge clk) begin
    exp_t got, e;
    got.s = samples_o; got.m = mid_o; got.d = done_o;
    if (rst) begin
      have_prev = 1'b0;
    end else begin
      if (have_prev) begin
        n_vec++;
        if (got !== prev) begin
          n_fail++;
          $display("FAIL stall_stable: got %h/%0d/%b held %h/%0d/%b",
                   got.s, got.m, got.d, prev.s, prev.m, prev.d);
        end
        have_prev = 1'b0;
      end
      if (valid_o) begin
        if (!ready_i) begin
          have_prev = 1'b1;
          prev = got;
        end else if (sb_q.size() == 0) begin
          n_vec++; n_fail++;
          $display("FAIL unexpected_beat: got %h/%0d/%b, required no output", got.s, got.m, got.d);
        end else begin
          e = sb_q.pop_front();
          n_vec++;
          if (got !== e) begin
            n_fail++;
            $display("FAIL beat: got samples=%h mid=%0d done=%b required samples=%h mid=%0d done=%b",
                     got.s, got.m, got.d, e.s, e.m, e.d);
          end
        end
      end else if (done_o) begin
        n_fail++;
        $display("FAIL done_idle: done_o=%b required 0 while valid_o=0", done_o);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    int t;
    logic [31:0] c100, c0, c255, c1only, c4only, c2only, c3only, c23, cmix;
    c100   = pk4(100, 100, 100, 100);
    c0     = pk4(0, 0, 0, 0);
    c255   = pk4(255, 255, 255, 255);
    c1only = pk4(255, 0, 0, 0);
    c4only = pk4(0, 0, 0, 255);
    c2only = pk4(0, 255, 0, 0);
    c3only = pk4(0, 0, 255, 0);
    c23    = pk4(0, 255, 255, 0);
    cmix   = pk4(200, 100, 50, 0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_valid_o", 64'(valid_o), 64'd0);
    chk("reset_done_o", 64'(done_o), 64'd0);
    chk("reset_samples_o", samples_o, 64'd0);
    chk("reset_mid_o", 64'(mid_o), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 64'(ready_o), 64'd1);

    // uniform corners, plain pass-through of axial and centre
    @(posedge clk); #1;
    send(0, 0, 55, pk4(10, 20, 30, 40), {c100, c100, c100, c100},
         pk8(10, 100, 20, 100, 30, 100, 40, 100));
    drain();

    // alternating bilinear / nearest beats back to back
    @(posedge clk); #1;
    send(0, 0, 9, pk4(1, 2, 3, 4), {c0, c255, c4only, c1only},
         pk8(1, 127, 2, 22, 3, 255, 4, 0));
    send(1, 0, 9, pk4(1, 2, 3, 4), {c0, c255, c4only, c1only},
         pk8(1, 255, 2, 0, 3, 255, 4, 0));
    send(0, 0, 77, pk4(11, 22, 33, 44), {cmix, c23, c3only, c2only},
         pk8(11, 53, 22, 53, 33, 106, 44, 131));
    send(1, 0, 77, pk4(11, 22, 33, 44), {cmix, c23, c3only, c2only},
         pk8(11, 0, 22, 0, 33, 0, 44, 200));
    drain();

    // six-beat stream with a four-cycle downstream stall; done on beat 6
    @(posedge clk); #1;
    fork
      begin
        for (int i = 1; i <= 6; i++) begin
          logic [31:0] cv;
          cv = pk4(10*i, 10*i, 10*i, 10*i);
          send(0, (i == 6), 100 + i, pk4(i, i + 1, i + 2, i + 3), {cv, cv, cv, cv},
               pk8(i, 10*i, i + 1, 10*i, i + 2, 10*i, i + 3, 10*i));
        end
      end
      begin
        repeat (2) @(posedge clk);
        #1 ready_i = 1'b0;
        repeat (4) @(posedge clk);
        #1 ready_i = 1'b1;
      end
    join
    drain();

    // reset with beats in flight: nothing may emerge afterwards
    @(posedge clk); #1;
    ready_i = 1'b0;
    send(0, 1, 1, pk4(1, 1, 1, 1), {c100, c100, c100, c100}, pk8(1, 100, 1, 100, 1, 100, 1, 100));
    send(0, 0, 2, pk4(2, 2, 2, 2), {c100, c100, c100, c100}, pk8(2, 100, 2, 100, 2, 100, 2, 100));
    send(0, 0, 3, pk4(3, 3, 3, 3), {c100, c100, c100, c100}, pk8(3, 100, 3, 100, 3, 100, 3, 100));
    t = 0;
    @(negedge clk);
    while (!valid_o && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("held_beat_present", 64'(valid_o), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_valid_o", 64'(valid_o), 64'd0);
    chk("async_reset_done_o", 64'(done_o), 64'd0);
    chk("async_reset_samples_o", samples_o, 64'd0);
    sb_q.delete();
    @(posedge clk); #1;
    ready_i = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_release", 64'(ready_o), 64'd1);
    repeat (10) @(negedge clk);
    chk("no_beat_after_reset", 64'(valid_o), 64'd0);

    // pipeline still functional after reset
    @(posedge clk); #1;
    send(0, 0, 200, pk4(5, 6, 7, 8), {c0, c255, c4only, c1only},
         pk8(5, 127, 6, 22, 7, 255, 8, 0));
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/circ_interp_pipe.md
CIRC_INTERP_PIPE -- requirements
Module: circ_interp_pipe

Interface
REQ-001 SHALL have parameter DW, default 8: pixel data width in bits.
REQ-002 SHALL have parameter FW, default 8: fractional weight width in bits.
REQ-003 SHALL have parameter W_FRAC, default 75: diagonal sub-pixel offset f = W_FRAC/2^FW (0.2929 for radius 1); legal range 0..2^FW.
REQ-004 SHALL use one clock and an asynchronous, active-high reset: clk is the clock and rst is the reset.
REQ-005 clk  in  1  clock; all state updates on its rising edge.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 valid_i  in  1  input beat valid.
REQ-008 ready_o  out  1  block accepts a beat this cycle.
REQ-009 mode_i  in  1  0 = bilinear, 1 = nearest-neighbour; sampled with the beat.
REQ-010 done_i  in  1  frame-end sideband; sampled only on an accepted beat.
REQ-011 mid_i  in  DW  centre pixel.
REQ-012 axial_i  in  4*DW  samples 0°,90°,180°,270°; 0° in LSBs.
REQ-013 diag_i  in  16*DW  four corners c1..c4 for each of 45°,135°,225°,315°, in that order, LSB first; c1 nearest the centre, c2/c3 adjacent, c4 farthest.
REQ-014 valid_o  out  1  output beat valid.
REQ-015 ready_i  in  1  downstream accepts the output beat.
REQ-016 samples_o  out  8*DW  S1..S8 = 0°,45°,90°,135°,180°,225°,270°,315°; S1 in LSBs.
REQ-017 mid_o  out  DW  centre pixel aligned with samples_o.
REQ-018 done_o  out  1  done_i sideband of the current output beat.

Function
REQ-019 SHALL be a 3-stage pipeline: S1 register inputs, S2 weighted products, S3 sum/round/output; latency from acceptance to valid_o is exactly 3 cycles without stalls.
REQ-020 SHALL use global-stall flow control: advance = !valid_o || ready_i; ready_o = advance; no stage updates when advance is 0.
REQ-021 SHALL accept a beat only when valid_i && ready_o; bubbles (valid_i=0) SHALL propagate as invalid stages.
REQ-022 While valid_o && !ready_i, samples_o, mid_o, done_o and valid_o SHALL remain stable.
REQ-023 Weights SHALL be constants: wa=(2^FW-W_FRAC)^2, wb=wc=W_FRAC*(2^FW-W_FRAC), wd=W_FRAC^2; sum = 2^(2*FW).
REQ-024 Bilinear diagonal sample SHALL be (wa*c1+wb*c2+wc*c3+wd*c4 + 2^(2*FW-1)) >> 2*FW, accumulated in at least 2*FW+DW+2 bits, then clamped to 2^DW-1.
REQ-025 In nearest mode each diagonal sample SHALL equal c1 unchanged.
REQ-026 Axial samples and mid SHALL pass through delayed 3 stages, unmodified in both modes.
REQ-027 mode_i and done_i SHALL travel with their beat; a mode change between consecutive beats SHALL affect only later beats.
REQ-028 done_o SHALL be high only while valid_o is high and only for the beat accepted with done_i=1.
REQ-029 W_FRAC=0 SHALL yield c1; W_FRAC=2^FW SHALL yield c4.

Reset
REQ-030 On rst: valid_o=0, done_o=0, samples_o=0, mid_o=0, all stage valids cleared, immediately and asynchronously.
REQ-031 Beats in flight at reset SHALL be discarded; ready_o SHALL be 1 in the first cycle after rst deasserts.

Verification
REQ-032 Defaults, bilinear, all corners 100, axial 10/20/30/40, mid 55 -> 3 cycles later S2/S4/S6/S8=100, S1=10, S3=20, S5=30, S7=40, mid_o=55.
REQ-033 Bilinear, 45° corners c1=255 rest 0 -> S2=127; c4=255 rest 0 -> S2=22; all 255 -> 255.
REQ-034 Same c1=255 case with mode_i=1 -> S2=255; alternating mode per beat -> per-beat results, no mixing.
REQ-035 Stream 6 back-to-back beats, ready_i low 4 cycles mid-stream -> no loss/duplication, outputs stable while stalled, order preserved.
REQ-036 done_i on beat 6 only -> done_o high exactly with output beat 6.
REQ-037 Assert rst with 2 beats in flight -> valid_o=0 at once, neither beat emitted after release.
